// File: rtl/apb3_ms_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb3_ms_pkg
// Description : Shared types and constants for the APB3 multi-requester
//               master (FSM state encoding, default bus widths, index width).
// Revision    : 1.0 - initial release
// ============================================================================
package apb3_ms_pkg;

  // APB3 master phase sequencing
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned C_DEF_ADDR_W = 32;
  localparam int unsigned C_DEF_DATA_W = 32;

  // Width needed to index n requesters (never below 1 bit)
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb3_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : apb3_rr_arb
// Description : Combinational round-robin picker. Returns the first eligible
//               requester at or above rr_ptr_i, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module apb3_rr_arb
  import apb3_ms_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_w(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // Scan offsets from the pointer upward; the first hit wins
  always_comb begin
    int unsigned cand;
    logic [IDX_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    grant_o  = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = 32'(rr_ptr_i) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!any_o && eligible_i[cand_idx]) begin
        any_o             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb3_m_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : apb3_m_arb_ctrl
// Description : Shares one APB3 master port between NUM_REQ requesters with
//               round-robin arbitration, one-cycle responses and an optional
//               PREADY timeout. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module apb3_m_arb_ctrl
  import apb3_ms_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = C_DEF_ADDR_W,
  parameter int unsigned DATA_W  = C_DEF_DATA_W,
  parameter int unsigned TIMEOUT = 16
)(
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      PSELx,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic                      PREADY,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PSLVERR
);

  localparam int unsigned C_IDX_W = idx_w(NUM_REQ);
  // Counter only has to reach TIMEOUT-1
  localparam int unsigned C_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  apb_state_e           state_q,     state_d;
  logic [C_IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [NUM_REQ-1:0]   grant_q,     grant_d;
  logic [C_TMO_W-1:0]   tmo_cnt_q,   tmo_cnt_d;
  logic                 psel_q,      psel_d;
  logic                 penable_q,   penable_d;
  logic                 pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0]    paddr_q,     paddr_d;
  logic [DATA_W-1:0]    pwdata_q,    pwdata_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q,   rsp_err_d;

  logic [ADDR_W-1:0]    w_addr  [NUM_REQ];
  logic [DATA_W-1:0]    w_wdata [NUM_REQ];
  logic [NUM_REQ-1:0]   w_eligible;
  logic [NUM_REQ-1:0]   w_arb_grant;
  logic [C_IDX_W-1:0]   w_arb_idx;
  logic                 w_arb_any;
  logic                 w_tmo_hit;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign w_wdata[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // The requester acknowledged this cycle sits out one arbitration round
  assign w_eligible = req_valid & ~rsp_valid_q;
  assign w_tmo_hit  = (TIMEOUT != 0) && (tmo_cnt_q == C_TMO_W'(TIMEOUT - 1));

  apb3_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (C_IDX_W)
  ) u_rr_arb (
    .eligible_i (w_eligible),
    .rr_ptr_i   (rr_ptr_q),
    .grant_o    (w_arb_grant),
    .idx_o      (w_arb_idx),
    .any_o      (w_arb_any)
  );

  // State and output registers; reset aborts any transfer in flight
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      tmo_cnt_q   <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      tmo_cnt_q   <= tmo_cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, then sequence SETUP and ACCESS
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    tmo_cnt_d   = tmo_cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (w_arb_any) begin
          grant_d   = w_arb_grant;
          pwrite_d  = req_write[w_arb_idx];
          paddr_d   = w_addr[w_arb_idx];
          pwdata_d  = w_wdata[w_arb_idx];
          rr_ptr_d  = (32'(w_arb_idx) == NUM_REQ - 1) ? '0 : w_arb_idx + 1'b1;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        tmo_cnt_d = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY takes priority over a timeout expiring on the same edge
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = grant_q;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          tmo_cnt_d   = '0;
          state_d     = IDLE;
        end else if (w_tmo_hit) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = grant_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          tmo_cnt_d   = '0;
          state_d     = IDLE;
        end else if (TIMEOUT != 0) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifndef SYNTHESIS
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_stable_chk
    // A pending command may only change in the cycle of its completion pulse
    a_req_stable: assert property (@(posedge PCLK) disable iff (!PRESETn)
      (req_valid[g] && $past(req_valid[g]) && !rsp_valid_q[g]) |->
      ($stable(req_write[g]) && $stable(w_addr[g]) && $stable(w_wdata[g])));
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb3_m_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb3_m_arb_ctrl
// Description : Directed bench for apb3_m_arb_ctrl; responses are checked
//               against a queue of expected completions.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_apb3_m_arb_ctrl;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic                      PCLK    = 1'b0;
  logic                      PRESETn = 1'b0;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      PSELx;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_W-1:0]         PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic                      PREADY;
  logic [DATA_W-1:0]         PRDATA;
  logic                      PSLVERR;

  typedef struct packed {
    logic [NUM_REQ-1:0] v;
    logic [DATA_W-1:0]  d;
    logic               e;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  apb3_m_arb_ctrl #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSELx     (PSELx),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(negedge PCLK);
  endtask

  task automatic set_cmd(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_write[i]               = w;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic push(input logic [NUM_REQ-1:0] v, input logic [31:0] d, input logic e);
    exp_t x;
    x.v = v;
    x.d = d;
    x.e = e;
    exp_q.push_back(x);
  endtask

  // Bounded wait for requester idx's completion pulse
  task automatic wait_rsp(input int idx, input int budget);
    int n;
    n = 0;
    while (rsp_valid[idx] !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("rsp_seen_%0d", idx), 32'(rsp_valid[idx]), 32'd1);
  endtask

  initial begin
    int pen_cnt;
    int got;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    PREADY    = 1'b1;
    PRDATA    = '0;
    PSLVERR   = 1'b0;

    fork
      // Scoreboard monitor: every completion pulse must match the queue head
      forever begin
        exp_t e;
        @(negedge PCLK);
        if (rsp_valid !== '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(e.v));
            chk("rsp_rdata", rsp_rdata, e.d);
            chk("rsp_err", 32'(rsp_err), 32'(e.e));
          end
        end
      end
    join_none

    // Reset state
    repeat (3) tick();
    chk("rst_psel_pen_pwrite", {29'd0, PSELx, PENABLE, PWRITE}, 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_rsp", {27'd0, rsp_valid, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    PRESETn = 1'b1;
    tick();

    // Single zero-wait write from requester 0
    set_cmd(0, 1'b1, 32'h10, 32'hDEADBEEF);
    push(4'b0001, 32'd0, 1'b0);
    req_valid[0] = 1'b1;
    tick();
    chk("t1_setup_psel_pen", {30'd0, PSELx, PENABLE}, 32'd2);
    chk("t1_paddr", PADDR, 32'h10);
    chk("t1_pwrite", 32'(PWRITE), 32'd1);
    chk("t1_pwdata", PWDATA, 32'hDEADBEEF);
    tick();
    chk("t1_access_psel_pen", {30'd0, PSELx, PENABLE}, 32'd3);
    tick();
    chk("t1_rsp_k3", 32'(rsp_valid), 32'd1);
    chk("t1_done_psel_pen", {30'd0, PSELx, PENABLE}, 32'd0);
    req_valid[0] = 1'b0;
    tick();
    chk("t1_paddr_hold", PADDR, 32'h10);
    chk("t1_idle_psel", 32'(PSELx), 32'd0);

    // Read with two wait states from requester 2
    PREADY = 1'b0;
    PRDATA = 32'hA5A5A5A5;
    set_cmd(2, 1'b0, 32'h20, 32'd0);
    push(4'b0100, 32'hA5A5A5A5, 1'b0);
    req_valid[2] = 1'b1;
    tick();
    chk("t2_paddr", PADDR, 32'h20);
    pen_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (PENABLE === 1'b1) pen_cnt++;
      if (pen_cnt == 3) PREADY = 1'b1;
      if (rsp_valid !== '0) break;
    end
    chk("t2_penable_cycles", 32'(pen_cnt), 32'd3);
    chk("t2_rsp_seen", 32'(rsp_valid), 32'h4);
    req_valid[2] = 1'b0;
    PREADY = 1'b1;
    tick();

    // Round-robin from a fresh pointer, all four held pending
    PRESETn = 1'b0;
    tick();
    PRESETn = 1'b1;
    PRDATA  = 32'h12345678;
    set_cmd(0, 1'b1, 32'h100, 32'h11111111);
    set_cmd(1, 1'b0, 32'h104, 32'd0);
    set_cmd(2, 1'b1, 32'h108, 32'h33333333);
    set_cmd(3, 1'b0, 32'h10C, 32'd0);
    push(4'b0001, 32'd0, 1'b0);
    push(4'b0010, 32'h12345678, 1'b0);
    push(4'b0100, 32'd0, 1'b0);
    push(4'b1000, 32'h12345678, 1'b0);
    push(4'b0001, 32'd0, 1'b0);
    tick();
    req_valid = 4'b1111;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rsp_valid !== '0) got++;
      if (got == 5) begin
        req_valid = '0;
        break;
      end
    end
    req_valid = '0;
    chk("t3_rsp_count", 32'(got), 32'd5);
    tick();

    // Slave error on a write, then a normal read
    PSLVERR = 1'b1;
    set_cmd(1, 1'b1, 32'h200, 32'hCAFEF00D);
    push(4'b0010, 32'd0, 1'b1);
    req_valid[1] = 1'b1;
    wait_rsp(1, 10);
    req_valid[1] = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0BADF00D;
    set_cmd(3, 1'b0, 32'h204, 32'd0);
    push(4'b1000, 32'h0BADF00D, 1'b0);
    req_valid[3] = 1'b1;
    wait_rsp(3, 10);
    req_valid[3] = 1'b0;
    tick();

    // PREADY stuck low: timeout after 16 ACCESS cycles
    PREADY = 1'b0;
    PRDATA = 32'hFFFFFFFF;
    set_cmd(0, 1'b0, 32'h300, 32'd0);
    push(4'b0001, 32'd0, 1'b1);
    req_valid[0] = 1'b1;
    pen_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (PENABLE === 1'b1) pen_cnt++;
      if (rsp_valid !== '0) break;
    end
    chk("t5_access_cycles", 32'(pen_cnt), 32'd16);
    chk("t5_rsp_seen", 32'(rsp_valid), 32'd1);
    req_valid[0] = 1'b0;
    tick();
    chk("t5_after_psel_pen", {30'd0, PSELx, PENABLE}, 32'd0);

    // Reset during ACCESS: abort silently, pointer back to requester 0
    set_cmd(1, 1'b1, 32'h400, 32'h44444444);
    req_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (PENABLE === 1'b1) break;
    end
    chk("t6_in_access", 32'(PENABLE), 32'd1);
    PRESETn = 1'b0;
    tick();
    chk("t6_rst_psel_pen", {30'd0, PSELx, PENABLE}, 32'd0);
    chk("t6_rst_no_rsp", 32'(rsp_valid), 32'd0);
    PRESETn = 1'b1;
    PREADY  = 1'b1;
    set_cmd(0, 1'b1, 32'h500, 32'h55555555);
    push(4'b0001, 32'd0, 1'b0);
    push(4'b0010, 32'd0, 1'b0);
    req_valid = 4'b0011;
    wait_rsp(0, 10);
    req_valid[0] = 1'b0;
    wait_rsp(1, 10);
    req_valid[1] = 1'b0;

    repeat (3) tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
